raizing_gfx_arbiter: RTL

- Parametrised arbiter that shares one graphics ROM port among `CHANNELS` layer fetchers (object, scroll 0/1/2, extra text).
- Each channel keeps a one-entry cache of its last fetched word, so repeated reads of the same address complete without a ROM access.
- It sits between the GCU tile fetch ports and the single SDRAM bank slot.
- It adds selectable round-robin or fixed-priority arbitration and a hung-request timeout.

---
 rtl/raizing_gfx_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/raizing_gfx_arbiter.sv
// ---------------------------------------------------------------------------
// raizing_gfx_arbiter
//
// Shares a single graphics ROM port (one SDRAM bank slot) among CHANNELS
// layer fetchers. Each channel keeps a one-entry cache of the last word it
// fetched, so repeated reads of the same address are answered without a ROM
// access. The policy is round-robin (PRIO_MODE=0) or fixed priority with
// channel 0 highest (PRIO_MODE=1). An optional timeout (TIMEOUT>0) abandons
// a fetch whose ROM_OK never arrives.
//
// Ports:
//   CLK, RESET        system clock, synchronous active-high reset
//   REQ_CS[i]         channel i wants data at REQ_ADDR[i*AW +: AW]
//   REQ_OK[i]         channel i cache holds the word for its current address
//   REQ_DOUT[i*DW+:DW] channel i cached word
//   ROM_CS/ROM_ADDR   request to the ROM slot, stable while waiting
//   ROM_OK/ROM_DOUT   ROM data valid / data
//   GRANT_ID          channel currently or most recently granted
//   BUSY              arbiter is not idle
//   TMO_ERR           sticky timeout flag, cleared only by RESET
// ---------------------------------------------------------------------------
module raizing_gfx_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int AW        = 22,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [CHANNELS-1:0]    REQ_CS,
    input  logic [CHANNELS*AW-1:0] REQ_ADDR,
    output logic [CHANNELS-1:0]    REQ_OK,
    output logic [CHANNELS*DW-1:0] REQ_DOUT,
    output logic                   ROM_CS,
    output logic [AW-1:0]          ROM_ADDR,
    input  logic                   ROM_OK,
    input  logic [DW-1:0]          ROM_DOUT,
    output logic [2:0]             GRANT_ID,
    output logic                   BUSY,
    output logic                   TMO_ERR
);

    // A zero-width counter is illegal, so the disabled-timeout build keeps
    // a one-bit counter that simply saturates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]          state;
    logic [AW-1:0]       caddr [CHANNELS];
    logic [DW-1:0]       cdata [CHANNELS];
    logic [CHANNELS-1:0] cval;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] pend;
    logic [2:0]          rr_ptr;
    logic [2:0]          win_id;
    logic                win_found;
    logic [AW-1:0]       win_addr;
    logic [CW-1:0]       wait_cnt;
    logic                wait_expired;

    // Cache lookup works on registered cache state, so a word written on an
    // edge becomes visible as a hit only in the following cycle.
    always_comb begin
        hit  = '0;
        pend = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]  = REQ_CS[i] & cval[i] & (REQ_ADDR[i*AW +: AW] == caddr[i]);
            pend[i] = REQ_CS[i] & ~hit[i];
        end
    end

    assign REQ_OK = hit;
    assign BUSY   = (state != ST_IDLE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_dout
        assign REQ_DOUT[i*DW +: DW] = cdata[i];
    end

    // Winner selection. The first pass looks only at channels at or above
    // rr_ptr (or at every channel in fixed-priority mode); the descending
    // loop leaves the lowest qualifying index. If nothing qualifies, the
    // second pass takes the lowest pending index, which is the wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_addr  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend[i] && (PRIO_MODE != 0 || 3'(i) >= rr_ptr)) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
        if (!win_found) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    win_found = 1'b1;
                    win_id    = 3'(i);
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (win_id == 3'(i)) begin
                win_addr = REQ_ADDR[i*AW +: AW];
            end
        end
    end

    // The counter reads 0 in the first WAIT cycle, so the fetch is abandoned
    // on the edge that would bring it to TIMEOUT, keeping ROM_CS high for
    // exactly TIMEOUT cycles.
    assign wait_expired = (TIMEOUT != 0) && ((int'(wait_cnt) + 1) >= TIMEOUT);

    // Main FSM. A fetch is never aborted when the requester changes address
    // or drops CS: the word is stored under the address actually fetched,
    // and a channel that moved on simply misses again and re-arbitrates.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            ROM_CS   <= 1'b0;
            ROM_ADDR <= '0;
            GRANT_ID <= '0;
            TMO_ERR  <= 1'b0;
            cval     <= '0;
            rr_ptr   <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                caddr[i] <= '0;
                cdata[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        ROM_ADDR <= win_addr;
                        GRANT_ID <= win_id;
                        ROM_CS   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                        if (PRIO_MODE == 0) begin
                            rr_ptr <= (win_id == 3'(CHANNELS - 1)) ? 3'd0 : win_id + 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ROM_OK) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (GRANT_ID == 3'(i)) begin
                                caddr[i] <= ROM_ADDR;
                                cdata[i] <= ROM_DOUT;
                                cval[i]  <= 1'b1;
                            end
                        end
                        ROM_CS <= 1'b0;
                        state  <= ST_GAP;
                    end else if (wait_expired) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (GRANT_ID == 3'(i)) begin
                                cval[i] <= 1'b0;
                            end
                        end
                        ROM_CS  <= 1'b0;
                        TMO_ERR <= 1'b1;
                        state   <= ST_GAP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // One cycle with ROM_CS low so the SDRAM slot sees a
                    // fresh request edge for the next grant.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
